// File: rtl/counter_bank_pkg.sv
// Shared types and next-state decision helper for the counter bank channels.
package counter_bank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CLEAR
  } ctr_op_e;

  // Where a channel's next counter value comes from; width-independent so the
  // helper serves any width_p without truncation.
  typedef enum logic [2:0] {
    SRC_CUR,
    SRC_INC,
    SRC_ZERO,
    SRC_LOAD,
    SRC_INIT
  } ctr_src_e;

  typedef struct packed {
    ctr_src_e src;
    logic     ovf;
  } ctr_next_t;

  function automatic ctr_next_t ctr_next(input ctr_op_e op, input logic at_max,
                                         input logic saturate, input logic ovf);
    ctr_next_t r;
    r.src = SRC_CUR;
    r.ovf = ovf;
    case (op)
      OP_CLEAR: begin
        r.src = SRC_INIT;
        r.ovf = 1'b0;
      end
      OP_LOAD: r.src = SRC_LOAD;
      OP_INC: begin
        if (at_max) begin
          r.ovf = 1'b1;
          r.src = saturate ? SRC_CUR : SRC_ZERO;
        end else begin
          r.src = SRC_INC;
        end
      end
      default: r.src = SRC_CUR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// One counter channel: counter register plus sticky overflow flag, driven by a decoded op.
module counter_bank_chan
  import counter_bank_pkg::*;
#(
  parameter int unsigned          width_p    = 32,
  parameter logic [width_p-1:0]   init_val_p = '0,
  parameter bit                   saturate_p = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  ctr_op_e            op,
  input  logic [width_p-1:0] load_val,
  output logic [width_p-1:0] ctr,
  output logic               ovf
);

  ctr_next_t          nxt;
  logic [width_p-1:0] ctr_nxt;

  always_comb begin
    nxt = ctr_next(op, &ctr, saturate_p, ovf);
    case (nxt.src)
      SRC_INC:  ctr_nxt = ctr + 1'b1;
      SRC_ZERO: ctr_nxt = '0;
      SRC_LOAD: ctr_nxt = load_val;
      SRC_INIT: ctr_nxt = init_val_p;
      default:  ctr_nxt = ctr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= init_val_p;
      ovf <= 1'b0;
    end else begin
      ctr <= ctr_nxt;
      ovf <= nxt.ovf;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of independent event counters with atomic shadow snapshot and registered
// single-channel readback.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned width_p    = 32,
  parameter int unsigned num_ctrs_p = 4,
  parameter int unsigned init_val_p = 0,
  parameter int unsigned saturate_p = 0,
  localparam int unsigned sel_w     = (num_ctrs_p > 1) ? $clog2(num_ctrs_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_ctrs_p-1:0]         en_i,
  input  logic [num_ctrs_p-1:0]         event_i,
  input  logic [num_ctrs_p-1:0]         clear_i,
  input  logic                          load_i,
  input  logic [sel_w-1:0]              load_sel_i,
  input  logic [width_p-1:0]            load_val_i,
  input  logic                          snapshot_i,
  input  logic [sel_w-1:0]              rd_sel_i,
  output logic [num_ctrs_p*width_p-1:0] ctr_r_o,
  output logic [num_ctrs_p-1:0]         ovf_r_o,
  output logic [width_p-1:0]            rd_data_o,
  output logic                          rd_ovf_o
);

  localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);
  localparam bit                 sat_lp  = (saturate_p != 0);

  logic [num_ctrs_p*width_p-1:0] shadow_ctr;
  logic [num_ctrs_p-1:0]         shadow_ovf;
  logic [width_p-1:0]            rd_data_nxt;
  logic                          rd_ovf_nxt;

  for (genvar k = 0; k < num_ctrs_p; k++) begin : g_chan
    ctr_op_e op;

    // Out-of-range load_sel_i matches no channel, so the load is dropped.
    always_comb begin
      if (clear_i[k])                                     op = OP_CLEAR;
      else if (load_i && (load_sel_i == sel_w'(k)))       op = OP_LOAD;
      else if (en_i[k] && event_i[k])                     op = OP_INC;
      else                                                op = OP_HOLD;
    end

    counter_bank_chan #(
      .width_p    (width_p),
      .init_val_p (init_lp),
      .saturate_p (sat_lp)
    ) u_chan (
      .clk      (clk_i),
      .rst      (reset_i),
      .op       (op),
      .load_val (load_val_i),
      .ctr      (ctr_r_o[k*width_p +: width_p]),
      .ovf      (ovf_r_o[k])
    );
  end

  // Shadow captures the pre-edge live registers, so same-cycle updates are excluded.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_ctr <= {num_ctrs_p{init_lp}};
      shadow_ovf <= '0;
    end else if (snapshot_i) begin
      shadow_ctr <= ctr_r_o;
      shadow_ovf <= ovf_r_o;
    end
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_ovf_nxt  = 1'b0;
    for (int k = 0; k < num_ctrs_p; k++) begin
      if (rd_sel_i == sel_w'(k)) begin
        rd_data_nxt = shadow_ctr[k*width_p +: width_p];
        rd_ovf_nxt  = shadow_ovf[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_o <= '0;
      rd_ovf_o  <= 1'b0;
    end else begin
      rd_data_o <= rd_data_nxt;
      rd_ovf_o  <= rd_ovf_nxt;
    end
  end

endmodule
